// File: rtl/palette_loader.sv
// Byte-serial palette download loader: assembles R,G,B triples, buffers them and
// schedules single-cycle palette RAM writes. Optional macro PALLOAD_BLANK_GATE_EN
// restricts writes to blanking cycles; when undefined, blank is ignored.
`timescale 1ns/1ps
module palette_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ENTRIES    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_data,
   output logic        dl_ready,
   input  logic        blank,
   output logic        load_color,
   output logic [23:0] load_color_data,
   output logic [5:0]  load_color_index,
   output logic        busy,
   output logic        done,
   output logic        short_err
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 30;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [6:0]         entry_cnt_q, entry_cnt_d;
   logic [7:0]         r_q, r_d, g_q, g_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               dl_ready_q, dl_ready_d;
   logic               load_color_q, load_color_d;
   logic [23:0]        data_q, data_d;
   logic [5:0]         index_q, index_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               short_err_q, short_err_d;
   logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
   logic               push, pop, accept, wr_window;
   logic [ENT_W-1:0]   push_data;

`ifdef PALLOAD_BLANK_GATE_EN
   assign wr_window = blank;
`else
   logic unused_blank;
   assign unused_blank = blank;
   assign wr_window    = 1'b1;
`endif

   assign accept = (state_q == LOAD) && dl_active && dl_wr && dl_ready_q;

   // Next-state, byte assembly, FIFO bookkeeping and write scheduling
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      entry_cnt_d = entry_cnt_q;
      r_d         = r_q;
      g_d         = g_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      load_color_d = 1'b0;
      data_d      = data_q;
      index_d     = index_q;
      done_d      = done_q;
      short_err_d = short_err_q;
      push        = 1'b0;
      pop         = 1'b0;
      push_data   = '0;

      case (state_q)
         IDLE, DONE: begin
            if (dl_active) begin
               state_d     = LOAD;
               byte_cnt_d  = 2'd0;
               entry_cnt_d = 7'd0;
               done_d      = 1'b0;
               short_err_d = 1'b0;
            end
         end
         LOAD: begin
            if (!dl_active) begin
               state_d    = DRAIN;
               byte_cnt_d = 2'd0;
               if (entry_cnt_q < 7'(ENTRIES)) short_err_d = 1'b1;
            end else if (accept && (entry_cnt_q < 7'(ENTRIES))) begin
               case (byte_cnt_q)
                  2'd0: begin
                     r_d        = dl_data;
                     byte_cnt_d = 2'd1;
                  end
                  2'd1: begin
                     g_d        = dl_data;
                     byte_cnt_d = 2'd2;
                  end
                  default: begin
                     push        = 1'b1;
                     push_data   = {r_q, g_q, dl_data, entry_cnt_q[5:0]};
                     entry_cnt_d = entry_cnt_q + 7'd1;
                     byte_cnt_d  = 2'd0;
                  end
               endcase
            end
         end
         DRAIN: begin
            if ((count_q == '0) && !load_color_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pop the head into the output registers; strobe is visible next cycle
      if (((state_q == LOAD) || (state_q == DRAIN)) && (count_q != '0) && wr_window) begin
         pop               = 1'b1;
         load_color_d      = 1'b1;
         {data_d, index_d} = fifo_q[rd_ptr_q];
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      busy_d = (state_d == LOAD) || (state_d == DRAIN);
      // Ready looks one cycle ahead so an accepted third byte always has a free slot
      dl_ready_d = (state_d == LOAD) &&
                   ((entry_cnt_d >= 7'(ENTRIES)) ||
                    !((byte_cnt_d == 2'd2) && (count_d == CNT_W'(FIFO_DEPTH))));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_cnt_q   <= 2'd0;
         entry_cnt_q  <= 7'd0;
         r_q          <= 8'd0;
         g_q          <= 8'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dl_ready_q   <= 1'b0;
         load_color_q <= 1'b0;
         data_q       <= 24'd0;
         index_q      <= 6'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         short_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         entry_cnt_q  <= entry_cnt_d;
         r_q          <= r_d;
         g_q          <= g_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dl_ready_q   <= dl_ready_d;
         load_color_q <= load_color_d;
         data_q       <= data_d;
         index_q      <= index_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         short_err_q  <= short_err_d;
      end
   end

   // Entry storage needs no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= push_data;
   end

   assign dl_ready         = dl_ready_q;
   assign load_color       = load_color_q;
   assign load_color_data  = data_q;
   assign load_color_index = index_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign short_err        = short_err_q;

endmodule

// File: tb/tb_palette_loader.sv
// Scoreboarded bench for palette_loader: a byte-level reference model queues the
// expected palette writes and an independent monitor checks each load_color strobe.
`timescale 1ns/1ps
module tb_palette_loader;

   logic        clk = 1'b0;
   logic        reset, dl_active, dl_wr, blank;
   logic [7:0]  dl_data;
   logic        dl_ready, load_color, busy, done, short_err;
   logic [23:0] load_color_data;
   logic [5:0]  load_color_index;

   always #5 clk = ~clk;

   palette_loader dut (
      .clk              (clk),
      .reset            (reset),
      .dl_active        (dl_active),
      .dl_wr            (dl_wr),
      .dl_data          (dl_data),
      .dl_ready         (dl_ready),
      .blank            (blank),
      .load_color       (load_color),
      .load_color_data  (load_color_data),
      .load_color_index (load_color_index),
      .busy             (busy),
      .done             (done),
      .short_err        (short_err)
   );

   int          errors = 0;
   int          checks = 0;
   logic [29:0] exp_q[$];
   int          wr_cnt = 0;
   logic [23:0] last_data = '0, first_data = '0;
   logic [5:0]  last_idx = '0;
   logic        prev_blank = 1'b0;

   // Reference model state: position within a triple and completed entries
   int          m_byte, m_entries;
   logic [7:0]  m_r, m_g;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) prev_blank <= blank;

   // Monitor: every write must match the oldest outstanding expected entry
   always @(negedge clk) begin : monitor
      logic [29:0] e;
      if (load_color === 1'b1) begin
         wr_cnt++;
         last_data = load_color_data;
         last_idx  = load_color_index;
         if (load_color_index == 6'd0) first_data = load_color_data;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: idx %0d data %06h with nothing expected",
                     load_color_index, load_color_data);
         end else begin
            e = exp_q.pop_front();
            if ({load_color_data, load_color_index} !== e) begin
               errors++;
               $display("FAIL write_content: got idx %0d data %06h expected idx %0d data %06h",
                        load_color_index, load_color_data, e[5:0], e[29:6]);
            end
         end
`ifdef PALLOAD_BLANK_GATE_EN
         checks++;
         if (prev_blank !== 1'b1) begin
            errors++;
            $display("FAIL write_outside_blank: blank was %b expected 1", prev_blank);
         end
`endif
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_accept(input logic [7:0] b);
      if (m_entries < 64) begin
         if (m_byte == 0) m_r = b;
         else if (m_byte == 1) m_g = b;
         else begin
            exp_q.push_back({m_r, m_g, b, 6'(m_entries)});
            m_entries++;
         end
         m_byte = (m_byte + 1) % 3;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard = 0;
      if (gap > 0) begin
         dl_wr = 1'b0;
         repeat (gap) step();
      end
      dl_wr   = 1'b1;
      dl_data = b;
      while (dl_ready !== 1'b1 && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: dl_ready stuck at %b expected 1", dl_ready);
      end else begin
         model_accept(b);
      end
      step();
   endtask

   task automatic start_session(output int base);
      m_byte    = 0;
      m_entries = 0;
      base      = wr_cnt;
      dl_active = 1'b1;
      step();
   endtask

   task automatic end_session(input string name, input int base, input int exp_writes,
                              input logic exp_short);
      int guard = 0;
      dl_wr     = 1'b0;
      dl_active = 1'b0;
      while (done !== 1'b1 && guard < 2000) begin
         step();
         guard++;
      end
      step();
      step();
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_short_err"}, 32'(short_err), 32'(exp_short));
      chk({name, "_busy_idle"}, 32'(busy), 32'd0);
      chk({name, "_writes"}, 32'(wr_cnt - base), 32'(exp_writes));
      chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_dl_ready"}, 32'(dl_ready), 32'd0);
      chk({name, "_load_color"}, 32'(load_color), 32'd0);
      chk({name, "_data"}, 32'(load_color_data), 32'd0);
      chk({name, "_index"}, 32'(load_color_index), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_done"}, 32'(done), 32'd0);
      chk({name, "_short_err"}, 32'(short_err), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base, w0, n, exp_n;
      logic saw_low, stop;
      reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'd0; blank = 1'b1;
      m_byte = 0; m_entries = 0; m_r = '0; m_g = '0;
      repeat (3) step();
      check_reset_outputs("reset");
      reset = 1'b0;
      step();

      // Full ascending download with an always-open window
      start_session(base);
      chk("s1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 192; i++) send_byte(8'(i), 0);
      end_session("s1", base, 64, 1'b0);
      chk("s1_first", 32'(first_data), 32'h000102);
      chk("s1_last", 32'(last_data), 32'hBDBEBF);
      chk("s1_last_idx", 32'(last_idx), 32'd63);

      // Window closed for 40 cycles: FIFO backs up and stalls the stream
      blank   = 1'b0;
      saw_low = 1'b0;
      start_session(base);
      w0 = wr_cnt;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               step();
               if (dl_ready === 1'b0) saw_low = 1'b1;
            end
            w0    = wr_cnt - w0;
            blank = 1'b1;
         end
         begin
            for (int i = 0; i < 192; i++) send_byte(8'($urandom), 0);
         end
      join
`ifdef PALLOAD_BLANK_GATE_EN
      chk("s2_ready_dropped", 32'(saw_low), 32'd1);
      chk("s2_no_write_closed", 32'(w0), 32'd0);
`else
      chk("s2_writes_ungated", 32'(w0 > 0), 32'd1);
`endif
      end_session("s2", base, 64, 1'b0);

      // Short download: 100 bytes -> 33 entries, trailing byte discarded
      start_session(base);
      for (int i = 0; i < 100; i++) send_byte(8'(i * 7 + 3), 0);
      end_session("s3", base, 33, 1'b1);
      chk("s3_last_idx", 32'(last_idx), 32'd32);

      // Overlong download: extra bytes accepted and dropped
      start_session(base);
      for (int i = 0; i < 200; i++) send_byte(8'($urandom), 0);
      end_session("s4", base, 64, 1'b0);
      chk("s4_last_idx", 32'(last_idx), 32'd63);

      // Reset mid-session: everything in flight is lost
      start_session(base);
      for (int i = 0; i < 50; i++) send_byte(8'($urandom), 0);
      reset = 1'b1; dl_wr = 1'b0; dl_active = 1'b0;
      exp_q.delete();
      step();
      check_reset_outputs("midreset");
      reset = 1'b0;
      w0 = wr_cnt;
      repeat (20) step();
      chk("midreset_no_writes", 32'(wr_cnt - w0), 32'd0);
      start_session(base);
      for (int i = 0; i < 192; i++) send_byte(8'($urandom), 0);
      end_session("s5", base, 64, 1'b0);

      // Randomized sessions: lengths, gaps and blanking pattern
      for (int s = 0; s < 3; s++) begin
         n     = int'($urandom_range(150, 220));
         exp_n = (n / 3 > 64) ? 64 : n / 3;
         stop  = 1'b0;
         start_session(base);
         fork
            begin
               while (!stop) begin
                  step();
                  blank = 1'($urandom_range(0, 1));
               end
            end
            begin
               for (int i = 0; i < n; i++)
                  send_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
               stop = 1'b1;
            end
         join
         blank = 1'b1;
         end_session($sformatf("rnd%0d", s), base, exp_n, exp_n < 64);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Sequences runtime loading of the 64-entry 24-bit custom palette RAM in the video block (palette 14) from a byte-serial download stream.
- Assembles R,G,B byte triples into entries and buffers them in a small FIFO.
- Schedules each entry as a single-cycle write (load_color/load_color_data/load_color_index) into the blanking window, because a write steals the RAM address from pixel lookup.
- Reports completion and short downloads to the system menu logic.

Parameters:
FIFO_DEPTH, 4, assembled-entry FIFO depth (power of 2, >=2)
ENTRIES, 64, palette entries expected per download

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
dl_active  in  1  download session in progress (level)
dl_wr  in  1  byte strobe; byte accepted when dl_wr & dl_ready
dl_data  in  8  download byte
dl_ready  out  1  loader can accept a byte this cycle
blank  in  1  write window (HBlank|VBlank from video), sampled each clk
load_color  out  1  palette RAM write strobe, one cycle per entry
load_color_data  out  24  {R,G,B}
load_color_index  out  6  entry index
busy  out  1  high in LOAD or DRAIN
done  out  1  last session completed, level
short_err  out  1  last session ended before ENTRIES complete triples, level

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Reset values: dl_ready=0, load_color=0, load_color_data=0, load_color_index=0, busy=0, done=0, short_err=0. Reset also selects state IDLE, flushes the FIFO and clears all counters.
- Reset asserted mid-session: no write issues in that cycle or afterwards. Bytes still in the FIFO are lost.
- States:
  - IDLE/DONE -> LOAD when dl_active=1. Entering LOAD clears byte_cnt(2b), entry_cnt(7b), done and short_err.
  - LOAD -> DRAIN when dl_active=0. If entry_cnt<ENTRIES, set short_err=1. A partial triple (byte_cnt!=0) is discarded.
  - DRAIN -> DONE when the FIFO is empty and no write is pending. Set done=1.
  - In DONE, dl_active=1 starts a new session the next cycle.
- Byte assembly (LOAD only):
  - Byte 0 goes to R, byte 1 to G, byte 2 to B.
  - On the byte-2 accept, push {R,G,B,entry_cnt[5:0]} into the FIFO, increment entry_cnt and wrap byte_cnt to 0.
- dl_ready, registered:
  - 0 outside LOAD.
  - In LOAD: 0 when byte_cnt==2 and the FIFO is full, otherwise 1.
  - After entry_cnt reaches ENTRIES, dl_ready=1 and bytes are accepted but dropped. No push occurs and the counters saturate.
- Write scheduler:
  - Active in LOAD and DRAIN.
  - In a cycle where the FIFO is non-empty and blank=1: pop the head and register it onto the outputs with load_color=1 for exactly the next cycle.
  - Latency: push to load_color is at least 2 cycles.
  - When blank=0, entries wait in the FIFO; no ordering change and no drop.
- Simultaneous push and pop on a full FIFO: the push is legal only if dl_ready was 1. Because dl_ready is computed from the previous cycle, a push never overflows.
- load_color_data and load_color_index hold their last value when load_color=0.
- Index wrap: indices are 0..63. No entry beyond index 63 is ever written.

Optional Feature:
- Macro: PALLOAD_BLANK_GATE_EN.
- Defined: writes occur only in cycles with blank=1, as specified above.
- Undefined: the blank input is ignored and writes issue whenever the FIFO is non-empty. This is for builds where the video core holds in reset during a download. The port still exists and is unused.

Test Plan:
- blank=1 constant, stream 192 bytes 00..BF -> 64 writes; entry 0 = 000102, entry 63 = BDBEBF at index 63; done=1, short_err=0.
- Stream 192 bytes with blank=0 for the first 40 cycles -> dl_ready drops to 0 once the FIFO holds 4 entries; resumes when blank=1; all 64 entries are written in order with no loss.
- Stream 100 bytes then deassert dl_active -> exactly 33 writes (indices 0..32); the final byte is discarded; short_err=1, done=1 after drain.
- Stream 200 bytes -> exactly 64 writes; the extra 8 bytes are accepted and dropped; short_err=0.
- Assert reset after 50 bytes -> all outputs 0 the next cycle; no further load_color. A new 192-byte session then completes normally from index 0.
- Build without PALLOAD_BLANK_GATE_EN, blank=0 constant, stream 192 bytes -> 64 writes complete; done=1.
